dsp48a1_op_sequencer: RTL and testbench

Command-side initiator for a DSP48A1 slice that runs with all clock enables held high.
- Accepts operand commands on a valid/ready interface and drives the slice's A/B/C/D/OPMODE/CARRYIN inputs.
- Tracks each command through the fixed slice pipeline latency and captures P/M/CARRYOUT into a result FIFO, which it presents on a valid/ready output.
- Owns the slice's reset: an initialisation pulse after reset, plus on-demand flushes.

---
 rtl/dsp48a1_op_sequencer.sv | 94 +++++++++
 tb/tb_dsp48a1_op_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp48a1_op_sequencer.sv
// dsp48a1_op_sequencer: drives a DSP48A1 slice from a command stream and buffers its results
module dsp48a1_op_sequencer #(
    parameter int LATENCY    = 4,
    parameter int RES_DEPTH  = 4,
    parameter int RST_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [17:0] cmd_a,
    input  logic [17:0] cmd_b,
    input  logic [47:0] cmd_c,
    input  logic [17:0] cmd_d,
    input  logic [7:0]  cmd_opmode,
    input  logic        cmd_carryin,
    input  logic        flush_req,
    output logic [17:0] dsp_A,
    output logic [17:0] dsp_B,
    output logic [47:0] dsp_C,
    output logic [17:0] dsp_D,
    output logic [7:0]  dsp_OPMODE,
    output logic        dsp_CARRYIN,
    output logic        dsp_CE,
    output logic        dsp_RST,
    input  logic [47:0] dsp_P,
    input  logic [35:0] dsp_M,
    input  logic        dsp_CARRYOUT,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [47:0] res_p,
    output logic [35:0] res_m,
    output logic        res_carryout,
    output logic        busy
);
    localparam int AW = $clog2(RES_DEPTH);
    localparam int CW = 6;
    typedef enum logic [1:0] {INIT_RST, INIT_FLUSH, RUN, DRAIN} state_t;
    state_t state, state_n;
    logic [4:0] cnt, cnt_n;
    logic [LATENCY-1:0] tag;
    logic [CW-1:0] inflight, count;
    logic [AW-1:0] wp, rp;
    logic [84:0] mem [RES_DEPTH];
    logic acc, push, pop;
    assign acc = cmd_valid && cmd_ready;
    assign push = tag[LATENCY-1];
    assign pop = res_valid && res_ready;
    assign cmd_ready = (state == RUN) && !flush_req && (inflight + count < CW'(RES_DEPTH));
    assign busy = (state != RUN) || (inflight != '0);
    assign dsp_CE = 1'b1;
    assign dsp_RST = (state == INIT_RST);
    assign res_valid = (count != '0);
    assign {res_p, res_m, res_carryout} = res_valid ? mem[rp] : '0;
    // next state: timed slice reset, pipeline flush, run, drain before re-reset
    always_comb begin
        state_n = state;
        cnt_n = '0;
        case (state)
            INIT_RST:   if (cnt == 5'(RST_CYCLES - 1)) state_n = INIT_FLUSH; else cnt_n = cnt + 5'd1;
            INIT_FLUSH: if (cnt == 5'(LATENCY - 1)) state_n = RUN; else cnt_n = cnt + 5'd1;
            RUN:        if (flush_req) state_n = DRAIN;
            default:    if (inflight == '0) state_n = INIT_RST;
        endcase
    end
    // state, tag pipeline, operand registers and FIFO bookkeeping
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= INIT_RST;
            cnt <= '0;
            tag <= '0;
            inflight <= '0;
            count <= '0;
            wp <= '0;
            rp <= '0;
            {dsp_A, dsp_B, dsp_C, dsp_D, dsp_OPMODE, dsp_CARRYIN} <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            tag <= (tag << 1) | LATENCY'(acc);
            inflight <= inflight + CW'(acc) - CW'(push);
            count <= count + CW'(push) - CW'(pop);
            wp <= push ? wp + AW'(1) : wp;
            rp <= pop ? rp + AW'(1) : rp;
            if (acc)
                {dsp_A, dsp_B, dsp_C, dsp_D, dsp_OPMODE, dsp_CARRYIN} <=
                    {cmd_a, cmd_b, cmd_c, cmd_d, cmd_opmode, cmd_carryin};
        end
    end
    // result storage: capture the slice outputs as the tag leaves the pipeline
    always_ff @(posedge CLK) begin
        if (push) mem[wp] <= {dsp_P, dsp_M, dsp_CARRYOUT};
    end
endmodule

// File: tb/tb_dsp48a1_op_sequencer.sv
// tb_dsp48a1_op_sequencer: directed self-checking bench with a latency-4 slice stand-in
module tb_dsp48a1_op_sequencer;
    logic        CLK = 1'b0;
    logic        RST_N;
    logic        cmd_valid, cmd_ready;
    logic [17:0] cmd_a, cmd_b, cmd_d;
    logic [47:0] cmd_c;
    logic [7:0]  cmd_opmode;
    logic        cmd_carryin, flush_req;
    logic [17:0] dsp_A, dsp_B, dsp_D;
    logic [47:0] dsp_C, dsp_P;
    logic [7:0]  dsp_OPMODE;
    logic        dsp_CARRYIN, dsp_CE, dsp_RST, dsp_CARRYOUT;
    logic [35:0] dsp_M;
    logic        res_valid, res_ready, res_carryout, busy;
    logic [47:0] res_p;
    logic [35:0] res_m;
    int compared = 0;
    int mismatched = 0;

    dsp48a1_op_sequencer dut (
        .CLK(CLK), .RST_N(RST_N),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c), .cmd_d(cmd_d),
        .cmd_opmode(cmd_opmode), .cmd_carryin(cmd_carryin), .flush_req(flush_req),
        .dsp_A(dsp_A), .dsp_B(dsp_B), .dsp_C(dsp_C), .dsp_D(dsp_D),
        .dsp_OPMODE(dsp_OPMODE), .dsp_CARRYIN(dsp_CARRYIN), .dsp_CE(dsp_CE), .dsp_RST(dsp_RST),
        .dsp_P(dsp_P), .dsp_M(dsp_M), .dsp_CARRYOUT(dsp_CARRYOUT),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_p(res_p), .res_m(res_m), .res_carryout(res_carryout), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // slice stand-in: M = A*B, P = (OPMODE[1:0]==01 ? M : 0) + C + CARRYIN, three register stages
    logic [35:0] mm;
    logic [48:0] ss;
    logic [84:0] pipe [3];
    assign mm = 36'(dsp_A) * 36'(dsp_B);
    assign ss = 49'((dsp_OPMODE[1:0] == 2'b01) ? {12'b0, mm} : 48'b0) + 49'(dsp_C) + 49'(dsp_CARRYIN);
    assign {dsp_P, dsp_M, dsp_CARRYOUT} = pipe[2];
    always @(posedge CLK) begin
        if (dsp_RST) begin
            pipe[0] <= '0;
            pipe[1] <= '0;
            pipe[2] <= '0;
        end else begin
            pipe[0] <= {ss[47:0], mm, ss[48]};
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
    end

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic set_cmd(input logic [17:0] a, input logic [17:0] b, input logic [47:0] c,
                           input logic [17:0] d, input logic [7:0] op, input logic cin);
        cmd_a = a;
        cmd_b = b;
        cmd_c = c;
        cmd_d = d;
        cmd_opmode = op;
        cmd_carryin = cin;
    endtask

    initial begin
        RST_N = 1'b0;
        cmd_valid = 1'b0;
        flush_req = 1'b0;
        res_ready = 1'b0;
        set_cmd(0, 0, 0, 0, 0, 0);
        #3;
        chk("rst_dsp_rst", dsp_RST, 1);
        chk("rst_dsp_ce", dsp_CE, 1);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_busy", busy, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_dsp_a", dsp_A, 0);
        chk("rst_res_p", res_p, 0);
        tick;
        tick;
        RST_N = 1'b1;
        tick;
        chk("init_rst_held", dsp_RST, 1);
        tick;
        chk("init_rst_released", dsp_RST, 0);
        repeat (3) tick;
        chk("init_flush_not_ready", cmd_ready, 0);
        chk("init_flush_busy", busy, 1);
        tick;
        chk("run_ready", cmd_ready, 1);
        chk("run_not_busy", busy, 0);
        chk("run_dsp_ce", dsp_CE, 1);

        set_cmd(5, 6, 0, 7, 8'h01, 0);
        cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
        chk("op_dsp_a", dsp_A, 5);
        chk("op_dsp_b", dsp_B, 6);
        chk("op_dsp_d", dsp_D, 7);
        chk("op_dsp_opmode", dsp_OPMODE, 1);
        chk("op_busy", busy, 1);
        repeat (3) tick;
        chk("op_not_yet", res_valid, 0);
        tick;
        chk("op_res_valid", res_valid, 1);
        chk("op_res_m", res_m, 36'h1E);
        chk("op_res_p", res_p, 48'h1E);
        chk("op_res_co", res_carryout, 0);
        chk("op_idle", busy, 0);
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        chk("op_popped", res_valid, 0);

        set_cmd(0, 0, 48'hFFFF_FFFF_FFFF, 0, 8'h00, 1);
        cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
        chk("co_dsp_carryin", dsp_CARRYIN, 1);
        repeat (4) tick;
        chk("co_res_p", res_p, 0);
        chk("co_res_carryout", res_carryout, 1);
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;

        for (int i = 0; i < 4; i++) begin
            set_cmd(18'(i + 1), 2, 0, 0, 8'h01, 0);
            cmd_valid = 1'b1;
            tick;
        end
        set_cmd(9, 2, 0, 0, 8'h01, 0);
        chk("credit_block", cmd_ready, 0);
        repeat (4) tick;
        chk("credit_hold_a", dsp_A, 4);
        chk("credit_full_valid", res_valid, 1);
        chk("credit_head0", res_m, 2);
        chk("credit_still_blocked", cmd_ready, 0);
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        chk("credit_reopen", cmd_ready, 1);
        chk("credit_head1", res_m, 4);
        tick;
        cmd_valid = 1'b0;
        chk("wrap_accept_a", dsp_A, 9);
        chk("wrap_credit", cmd_ready, 0);
        repeat (3) tick;
        res_ready = 1'b1;
        tick;
        chk("wrap_pushpop_valid", res_valid, 1);
        chk("wrap_head2", res_m, 6);
        tick;
        chk("wrap_head3", res_m, 8);
        tick;
        chk("wrap_head4_m", res_m, 36'h12);
        chk("wrap_head4_p", res_p, 48'h12);
        tick;
        res_ready = 1'b0;
        chk("wrap_empty", res_valid, 0);

        set_cmd(3, 3, 0, 0, 8'h01, 0);
        cmd_valid = 1'b1;
        tick;
        set_cmd(7, 1, 0, 0, 8'h01, 0);
        tick;
        set_cmd(15, 1, 0, 0, 8'h01, 0);
        flush_req = 1'b1;
        #1;
        chk("flush_blocks_cmd", cmd_ready, 0);
        tick;
        flush_req = 1'b0;
        cmd_valid = 1'b0;
        chk("drain_not_ready", cmd_ready, 0);
        chk("drain_busy", busy, 1);
        chk("drain_cmd_dropped", dsp_A, 7);
        tick;
        tick;
        chk("drain_first_result", res_valid, 1);
        tick;
        chk("drain_no_rst_yet", dsp_RST, 0);
        tick;
        chk("reinit_rst_1", dsp_RST, 1);
        tick;
        chk("reinit_rst_2", dsp_RST, 1);
        tick;
        chk("reinit_rst_off", dsp_RST, 0);
        repeat (3) tick;
        chk("reinit_flush_not_ready", cmd_ready, 0);
        tick;
        chk("reinit_run_ready", cmd_ready, 1);
        chk("reinit_keep0", res_m, 9);
        res_ready = 1'b1;
        tick;
        chk("reinit_keep1", res_m, 7);
        tick;
        res_ready = 1'b0;
        chk("reinit_drained", res_valid, 0);

        set_cmd(2, 2, 0, 0, 8'h01, 0);
        cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
        repeat (4) tick;
        chk("mid_buffered", res_valid, 1);
        for (int i = 0; i < 3; i++) begin
            set_cmd(18'(i + 1), 1, 0, 0, 8'h01, 0);
            cmd_valid = 1'b1;
            tick;
        end
        cmd_valid = 1'b0;
        chk("mid_busy", busy, 1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 0);
        chk("mid_rst_dsp_rst", dsp_RST, 1);
        chk("mid_rst_busy", busy, 1);
        chk("mid_rst_dsp_a", dsp_A, 0);
        tick;
        tick;
        RST_N = 1'b1;
        repeat (6) tick;
        chk("mid_rerun_ready", cmd_ready, 1);
        chk("mid_rerun_empty", res_valid, 0);
        repeat (8) tick;
        chk("mid_no_stale", res_valid, 0);
        chk("mid_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
